// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx
// Function : UART transmitter, 8N1, LSB first, fixed CLKS_PER_BIT bit timing.
//            Define UART_TX_PARITY_EN to insert a parity bit (8E1 / 8O1).
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_ODD   = 0
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Tx_DV,
  input  logic [7:0] i_Tx_Byte,
  output logic       o_Tx_Serial,
  output logic       o_Tx_Active,
  output logic       o_Tx_Done
);

  localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    CLEANUP = 3'd4
`ifdef UART_TX_PARITY_EN
    , PARITY = 3'd5
`endif
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  byte_q, byte_d;
  logic        serial_q, serial_d;
  logic        active_q, active_d;
  logic        done_q, done_d;
  logic        w_bit_end;
  logic        w_after_data;

`ifdef UART_TX_PARITY_EN
  assign w_after_data = (^byte_q) ^ (PARITY_ODD != 0);
`else
  logic unused_parity_odd;
  assign unused_parity_odd = (PARITY_ODD != 0);
  assign w_after_data      = 1'b1;
`endif

  assign w_bit_end = (cnt_q == LAST_CNT);

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q  <= IDLE;
      cnt_q    <= 16'd0;
      idx_q    <= 3'd0;
      byte_q   <= 8'd0;
      serial_q <= 1'b1;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      byte_q   <= byte_d;
      serial_q <= serial_d;
      active_q <= active_d;
      done_q   <= done_d;
    end
  end

  // Outputs are registered, so each branch computes the line level for the
  // cycle that follows the edge, not the current one.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    byte_d   = byte_q;
    serial_d = serial_q;
    active_d = active_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        serial_d = 1'b1;
        active_d = 1'b0;
        cnt_d    = 16'd0;
        idx_d    = 3'd0;
        if (i_Tx_DV) begin
          byte_d   = i_Tx_Byte;
          state_d  = START;
          serial_d = 1'b0;
          active_d = 1'b1;
        end
      end

      START: begin
        serial_d = 1'b0;
        if (w_bit_end) begin
          cnt_d    = 16'd0;
          state_d  = DATA;
          serial_d = byte_q[0];
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      DATA: begin
        serial_d = byte_q[idx_q];
        if (w_bit_end) begin
          cnt_d = 16'd0;
          if (idx_q != 3'd7) begin
            idx_d    = idx_q + 3'd1;
            serial_d = byte_q[idx_q + 3'd1];
          end else begin
            idx_d    = 3'd0;
            serial_d = w_after_data;
`ifdef UART_TX_PARITY_EN
            state_d  = PARITY;
`else
            state_d  = STOP;
`endif
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

`ifdef UART_TX_PARITY_EN
      PARITY: begin
        serial_d = w_after_data;
        if (w_bit_end) begin
          cnt_d    = 16'd0;
          state_d  = STOP;
          serial_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
`endif

      STOP: begin
        serial_d = 1'b1;
        if (w_bit_end) begin
          cnt_d    = 16'd0;
          state_d  = CLEANUP;
          active_d = 1'b0;
          done_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      CLEANUP: begin
        serial_d = 1'b1;
        active_d = 1'b0;
        state_d  = IDLE;
      end

      default: begin
        state_d  = IDLE;
        serial_d = 1'b1;
        active_d = 1'b0;
        cnt_d    = 16'd0;
        idx_d    = 3'd0;
      end
    endcase
  end

  assign o_Tx_Serial = serial_q;
  assign o_Tx_Active = active_q;
  assign o_Tx_Done   = done_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx
// Function : Directed bench for uart_tx (CLKS_PER_BIT=4), even and odd parity
//            instances driven in parallel.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam logic PAR_EN = 1'b1;
  localparam int   FLEN   = 11 * CPB;
`else
  localparam logic PAR_EN = 1'b0;
  localparam int   FLEN   = 10 * CPB;
`endif
  localparam int GAP = FLEN + 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tx_dv = 1'b0;
  logic [7:0] tx_byte = 8'h00;
  logic       ser0, act0, done0;
  logic       ser1, act1, done1;

  int vectors = 0;
  int miscompares = 0;

  logic ln0 [0:255];
  logic ac0 [0:255];
  logic dn0 [0:255];
  logic ln1 [0:255];
  logic ac1 [0:255];
  logic dn1 [0:255];

  always #5 clk = ~clk;

  uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_ODD(0)) dut_even (
    .i_Clock(clk), .i_Reset(rst), .i_Tx_DV(tx_dv), .i_Tx_Byte(tx_byte),
    .o_Tx_Serial(ser0), .o_Tx_Active(act0), .o_Tx_Done(done0)
  );

  uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_ODD(1)) dut_odd (
    .i_Clock(clk), .i_Reset(rst), .i_Tx_DV(tx_dv), .i_Tx_Byte(tx_byte),
    .o_Tx_Serial(ser1), .o_Tx_Active(act1), .o_Tx_Done(done1)
  );

  // Expected line level k cycles after the accept edge of a frame.
  function automatic logic exp_line(input logic [7:0] b, input int k,
                                    input logic par_en, input logic par);
    int bitn;
    if (k < 0) return 1'b1;
    bitn = k / CPB;
    if (bitn == 0) return 1'b0;
    if (bitn <= 8) return b[bitn-1];
    if (bitn == 9 && par_en) return par;
    return 1'b1;
  endfunction

  // Pulses a request, then records n samples; sample k is taken on the
  // falling edge after rising edge accept+k. pa/pb add extra request pulses
  // carrying alt; hold keeps the request high until the last sample.
  task automatic send_capture(input logic [7:0] b, input int n, input int pa,
                              input int pb, input logic [7:0] alt, input logic hold);
    @(negedge clk);
    tx_dv   = 1'b1;
    tx_byte = b;
    @(negedge clk);
    for (int k = 0; k < n; k++) begin
      ln0[k] = ser0; ac0[k] = act0; dn0[k] = done0;
      ln1[k] = ser1; ac1[k] = act1; dn1[k] = done1;
      if (k == pa || k == pb) tx_byte = alt;
      tx_dv = (hold && k < n - 1) || k == pa || k == pb;
      if (k < n - 1) @(negedge clk);
    end
    tx_dv = 1'b0;
  endtask

  task automatic test_reset;
    int bad;
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({ser0, act0, done0} !== 3'b100) begin
      miscompares++;
      $display("FAIL reset_async: got ser/act/done=%b expected 100", {ser0, act0, done0});
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if ({ser0, act0, done0, ser1, act1, done1} !== 6'b100100) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL reset_idle: got %0d non-idle cycles expected 0", bad);
    end
  endtask

  task automatic test_single;
    logic [2:0] exp;
    send_capture(8'hA5, FLEN + 4, -1, -1, 8'h00, 1'b0);
    for (int k = 0; k < FLEN + 4; k++) begin
      exp = {exp_line(8'hA5, k, PAR_EN, ^8'hA5), k < FLEN, k == FLEN};
      vectors++;
      if ({ln0[k], ac0[k], dn0[k]} !== exp) begin
        miscompares++;
        $display("FAIL single_A5 k=%0d: got line/act/done=%b expected %b",
                 k, {ln0[k], ac0[k], dn0[k]}, exp);
      end
    end
  endtask

  task automatic test_ignored;
    logic [2:0] exp;
    send_capture(8'h3C, 100, 17, FLEN, 8'hFF, 1'b0);
    for (int k = 0; k < 100; k++) begin
      exp = {exp_line(8'h3C, k, PAR_EN, ^8'h3C), k < FLEN, k == FLEN};
      vectors++;
      if ({ln0[k], ac0[k], dn0[k]} !== exp) begin
        miscompares++;
        $display("FAIL ignored_3C k=%0d: got line/act/done=%b expected %b",
                 k, {ln0[k], ac0[k], dn0[k]}, exp);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [2:0] exp;
    int         j;
    send_capture(8'h01, 2 * GAP, 0, -1, 8'h80, 1'b1);
    for (int k = 0; k < 2 * GAP; k++) begin
      if (k < GAP) exp = {exp_line(8'h01, k, PAR_EN, ^8'h01), k < FLEN, k == FLEN};
      else begin
        j   = k - GAP;
        exp = {exp_line(8'h80, j, PAR_EN, ^8'h80), j < FLEN, j == FLEN};
      end
      vectors++;
      if ({ln0[k], ac0[k], dn0[k]} !== exp) begin
        miscompares++;
        $display("FAIL back_to_back k=%0d: got line/act/done=%b expected %b",
                 k, {ln0[k], ac0[k], dn0[k]}, exp);
      end
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_midframe;
    logic [2:0] exp;
    int         bad;
    // Sample 25 falls inside data bit 5 (line low for 8'h00).
    send_capture(8'h00, 26, -1, -1, 8'h00, 1'b0);
    vectors++;
    if ({ser0, act0} !== 2'b01) begin
      miscompares++;
      $display("FAIL midframe_pre: got line/act=%b expected 01", {ser0, act0});
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({ser0, act0, done0} !== 3'b100) begin
      miscompares++;
      $display("FAIL midframe_async: got ser/act/done=%b expected 100", {ser0, act0, done0});
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if ({ser0, act0, done0} !== 3'b100) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL midframe_nodone: got %0d non-idle cycles expected 0", bad);
    end
    send_capture(8'hC3, FLEN + 4, -1, -1, 8'h00, 1'b0);
    for (int k = 0; k < FLEN + 4; k++) begin
      exp = {exp_line(8'hC3, k, PAR_EN, ^8'hC3), k < FLEN, k == FLEN};
      vectors++;
      if ({ln0[k], ac0[k], dn0[k]} !== exp) begin
        miscompares++;
        $display("FAIL after_reset_C3 k=%0d: got line/act/done=%b expected %b",
                 k, {ln0[k], ac0[k], dn0[k]}, exp);
      end
    end
  endtask

  task automatic test_parity;
    logic [2:0] exp0, exp1;
    send_capture(8'h07, FLEN + 4, -1, -1, 8'h00, 1'b0);
    for (int k = 0; k < FLEN + 4; k++) begin
      // 8'h07 has three ones: even parity bit 1, odd parity bit 0.
      exp0 = {exp_line(8'h07, k, PAR_EN, 1'b1), k < FLEN, k == FLEN};
      exp1 = {exp_line(8'h07, k, PAR_EN, 1'b0), k < FLEN, k == FLEN};
      vectors++;
      if ({ln0[k], ac0[k], dn0[k]} !== exp0) begin
        miscompares++;
        $display("FAIL parity_even_07 k=%0d: got line/act/done=%b expected %b",
                 k, {ln0[k], ac0[k], dn0[k]}, exp0);
      end
      vectors++;
      if ({ln1[k], ac1[k], dn1[k]} !== exp1) begin
        miscompares++;
        $display("FAIL parity_odd_07 k=%0d: got line/act/done=%b expected %b",
                 k, {ln1[k], ac1[k], dn1[k]}, exp1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_ignored();
    test_back_to_back();
    test_reset_midframe();
    test_parity();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- 8N1 UART transmitter. Serialises one byte per request onto an idle-high line, LSB first.
- Bit timing comes from a fixed clocks-per-bit count.
- Pairs with the arbiter's receiver: same bit timing, same frame format, same strobe-style data-valid handshake.
- Sits between the arbiter's command logic and the serial output pin.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per serial bit; legal range 2..65535.
- PARITY_ODD, 0, parity sense when parity is compiled in: 0 = even, 1 = odd. Ignored otherwise.

Ports:
- i_Clock  input  1  system clock; all logic on the rising edge.
- i_Reset  input  1  asynchronous reset, active-high.
- i_Tx_DV  input  1  one-cycle request strobe; byte accepted only in IDLE.
- i_Tx_Byte  input  8  byte to send; sampled in the accept cycle only.
- o_Tx_Serial  output  1  serial line; idle high.
- o_Tx_Active  output  1  high while a frame is on the line.
- o_Tx_Done  output  1  one-cycle pulse after the stop bit completes.

Behaviour:
- Reset (asynchronous, active-high), applied immediately, including mid-frame:
  - o_Tx_Serial=1, o_Tx_Active=0, o_Tx_Done=0.
  - State=IDLE; clock counter, bit index and shift register all cleared.
  - A frame cut off by reset produces no o_Tx_Done.
- All outputs are registered.
- Clock counter is 16 bits, counts 0..CLKS_PER_BIT-1, and never wraps past terminal.
- Bit index is 3 bits, 0..7.
- States: IDLE, START, DATA, PARITY (macro only), STOP, CLEANUP.
- IDLE:
  - o_Tx_Serial=1, o_Tx_Active=0, counter=0, index=0.
  - If i_Tx_DV=1: latch i_Tx_Byte, go to START, set o_Tx_Active=1 on the next edge.
- START:
  - o_Tx_Serial=0 for exactly CLKS_PER_BIT cycles, beginning the cycle after the accept.
  - At count CLKS_PER_BIT-1: clear counter, go to DATA.
- DATA:
  - o_Tx_Serial=byte[index] for CLKS_PER_BIT cycles per bit.
  - At terminal count: if index<7, increment index; else index=0 and go to PARITY (macro) or STOP.
- STOP:
  - o_Tx_Serial=1 for CLKS_PER_BIT cycles.
  - At terminal count: o_Tx_Active=0, o_Tx_Done=1, go to CLEANUP.
- CLEANUP:
  - Exactly one cycle; o_Tx_Done=1 during it, cleared on exit; line stays 1.
  - Go to IDLE.
- Handshake:
  - i_Tx_DV is ignored outside IDLE, including during CLEANUP. No queuing, no error flag.
  - i_Tx_Byte changes after the accept cycle do not affect the frame in flight.
- Latency:
  - Accept edge to start-bit falling edge: 1 cycle.
  - Frame length: 10×CLKS_PER_BIT cycles (11× with parity).
  - Minimum accept-to-accept spacing: frame length + 2 cycles.
- Back-to-back: i_Tx_DV held high continuously re-accepts in the first IDLE cycle after CLEANUP. Only the byte present in that cycle is sent.
- Unused state encodings return to IDLE with line high.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - PARITY state inserted between DATA and STOP.
  - o_Tx_Serial=^byte XOR PARITY_ODD for CLKS_PER_BIT cycles.
  - Frame is 8E1 (PARITY_ODD=0) or 8O1 (PARITY_ODD=1).
- Undefined:
  - No PARITY state and no parity logic; PARITY_ODD has no effect.
  - Frame is 8N1.

Test Plan:
- Reset/idle: assert i_Reset mid-cycle with no clock edge → o_Tx_Serial=1, o_Tx_Active=0, o_Tx_Done=0 immediately. After release with i_Tx_DV=0 for 100 cycles, outputs are unchanged.
- Single byte, CLKS_PER_BIT=4: pulse i_Tx_DV with 8'hA5 →
  - Line reads 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles, first low 1 cycle after accept.
  - o_Tx_Active high for 40 cycles; o_Tx_Done high exactly 1 cycle after them.
- Ignored request: during the frame for 8'h3C, pulse i_Tx_DV with 8'hFF at bit 3 and again in the CLEANUP cycle → only 8'h3C appears; no second frame, no extra o_Tx_Done.
- Back-to-back: hold i_Tx_DV=1 while presenting 8'h01, then 8'h80 (changed after the first accept) → two frames, 8'h01 then 8'h80. Second start bit begins 42 cycles after the first with CLKS_PER_BIT=4.
- Reset mid-frame: assert i_Reset during data bit 5 of 8'h00 → line goes 1 asynchronously, no o_Tx_Done. A new request after release sends a complete, correct frame.
- Parity (UART_TX_PARITY_EN, CLKS_PER_BIT=4):
  - 8'h07 with PARITY_ODD=0 → parity bit 1; frame is 44 cycles.
  - 8'h07 with PARITY_ODD=1 → parity bit 0.
  - Without the macro, the same stimulus gives a 40-cycle 8N1 frame.
